// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling FSM, valid/ready holding register.
// Framing errors and overruns are reported as single-cycle pulses.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
    localparam int unsigned CntW     = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfLast = CntW'(HALF_BIT - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StStart    = 3'd1,
        StData     = 3'd2,
        StStop     = 3'd3,
        StWaitHigh = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic            sync1_q, sync2_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            fe_q, fe_d;
    logic            ov_q, ov_d;
    logic            deliver;
    logic            rx_s;

    assign rx_s = sync2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        fe_d    = 1'b0;
        ov_d    = 1'b0;
        deliver = 1'b0;

        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                bit_d = '0;
                if (!rx_s) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == HalfLast) begin
                    cnt_d   = '0;
                    // A high line at mid start bit is a glitch, not a frame.
                    state_d = rx_s ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == BitLast) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (cnt_q == BitLast) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        deliver = 1'b1;
                        state_d = StIdle;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = StWaitHigh;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitHigh: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase

        // A same-edge consume frees the holding register for the new byte.
        if (deliver) begin
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ov_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = fe_q;
    assign overrun   = ov_q;
    assign busy      = (state_q != StIdle);
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: frames, glitch, framing error,
// overrun, mid-frame reset and back-to-back reception.
module tb_uart_rx;
    logic       clk;
    logic       rst_n;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_vec;
    int n_err;

    // Event tallies gathered on the falling edge, away from the active edge.
    int         vcyc;
    int         fe_cnt;
    int         ov_cnt;
    int         got_n;
    logic [7:0] got_data [0:63];

    uart_rx #(.CLKS_PER_BIT(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_in    (rx_in),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        vcyc   = 0;
        fe_cnt = 0;
        ov_cnt = 0;
        got_n  = 0;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) vcyc = vcyc + 1;
            if (frame_err) fe_cnt = fe_cnt + 1;
            if (overrun) ov_cnt = ov_cnt + 1;
            if (rx_valid && rx_ready && got_n < 64) begin
                got_data[got_n] = rx_data;
                got_n = got_n + 1;
            end
        end
    end

    // Called at posedge+1; drives start, 8 data bits LSB first, stop, 16 clocks each.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx_in = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            repeat (16) @(posedge clk);
            #1;
        end
        rx_in = stop_bit;
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        rx_in    = 1'b1;
        rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (rx_valid !== 1'b0 || rx_data !== 8'h00 || frame_err !== 1'b0 ||
            overrun !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got valid=%b data=%h fe=%b ov=%b busy=%b, want all 0",
                     rx_valid, rx_data, frame_err, overrun, busy);
        end
        rst_n = 1'b1;
        idle(5);
    endtask

    task automatic test_basic();
        int v0 = vcyc, f0 = fe_cnt, o0 = ov_cnt, g0 = got_n;
        send_frame(8'hA5, 1'b1);
        idle(20);
        n_vec++;
        if (vcyc - v0 !== 1) begin
            n_err++;
            $display("FAIL basic_valid_cycles: got %0d, want 1", vcyc - v0);
        end
        n_vec++;
        if (got_n - g0 !== 1 || got_data[g0] !== 8'hA5) begin
            n_err++;
            $display("FAIL basic_data: got n=%0d data=%h, want n=1 data=a5", got_n - g0,
                     got_data[g0]);
        end
        n_vec++;
        if (fe_cnt - f0 !== 0 || ov_cnt - o0 !== 0) begin
            n_err++;
            $display("FAIL basic_errors: got fe=%0d ov=%0d, want 0 0", fe_cnt - f0, ov_cnt - o0);
        end
    endtask

    task automatic test_glitch();
        int v0 = vcyc, f0 = fe_cnt;
        rx_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL glitch_busy_during: got %b, want 1", busy);
        end
        idle(30);
        n_vec++;
        if (rx_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0 ||
            vcyc - v0 !== 0 || fe_cnt - f0 !== 0) begin
            n_err++;
            $display("FAIL glitch_after: got valid=%b fe=%b busy=%b vc=%0d fc=%0d, want 0s",
                     rx_valid, frame_err, busy, vcyc - v0, fe_cnt - f0);
        end
    endtask

    task automatic test_frame_err();
        int v0 = vcyc, f0 = fe_cnt, g0 = got_n;
        send_frame(8'h3C, 1'b0);
        rx_in = 1'b0;
        repeat (24) @(posedge clk);
        #1;
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL ferr_wait_high_busy: got %b, want 1", busy);
        end
        idle(20);
        n_vec++;
        if (fe_cnt - f0 !== 1 || vcyc - v0 !== 0) begin
            n_err++;
            $display("FAIL ferr_pulse: got fe=%0d valid_cycles=%0d, want 1 0", fe_cnt - f0,
                     vcyc - v0);
        end
        send_frame(8'h81, 1'b1);
        idle(20);
        n_vec++;
        if (got_n - g0 !== 1 || got_data[g0] !== 8'h81) begin
            n_err++;
            $display("FAIL ferr_recover: got n=%0d data=%h, want n=1 data=81", got_n - g0,
                     got_data[g0]);
        end
    endtask

    task automatic test_overrun();
        int o0 = ov_cnt, g0 = got_n;
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        idle(4);
        send_frame(8'h22, 1'b1);
        idle(20);
        n_vec++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
            n_err++;
            $display("FAIL overrun_hold: got valid=%b data=%h, want 1 11", rx_valid, rx_data);
        end
        n_vec++;
        if (ov_cnt - o0 !== 1) begin
            n_err++;
            $display("FAIL overrun_pulse: got %0d, want 1", ov_cnt - o0);
        end
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (rx_valid !== 1'b0 || got_n - g0 !== 1 || got_data[g0] !== 8'h11) begin
            n_err++;
            $display("FAIL overrun_accept: got valid=%b n=%0d data=%h, want 0 1 11", rx_valid,
                     got_n - g0, got_data[g0]);
        end
        idle(5);
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        int g0;
        b = 8'h5A;
        rx_in = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            rx_in = b[i];
            repeat (16) @(posedge clk);
            #1;
        end
        rx_in = b[4];
        repeat (8) @(posedge clk);
        #1;
        n_vec++;
        if (busy !== 1'b1 || rx_data !== 8'h11) begin
            n_err++;
            $display("FAIL midrst_before: got busy=%b data=%h, want 1 11", busy, rx_data);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (rx_valid !== 1'b0 || rx_data !== 8'h00 || frame_err !== 1'b0 ||
            overrun !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_clear: got valid=%b data=%h fe=%b ov=%b busy=%b, want 0s",
                     rx_valid, rx_data, frame_err, overrun, busy);
        end
        rx_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(5);
        g0 = got_n;
        send_frame(8'h5A, 1'b1);
        idle(20);
        n_vec++;
        if (got_n - g0 !== 1 || got_data[g0] !== 8'h5A) begin
            n_err++;
            $display("FAIL midrst_after: got n=%0d data=%h, want n=1 data=5a", got_n - g0,
                     got_data[g0]);
        end
    endtask

    task automatic test_back_to_back();
        int f0 = fe_cnt, o0 = ov_cnt, g0 = got_n;
        logic [7:0] exp [0:2];
        exp[0] = 8'h00;
        exp[1] = 8'hFF;
        exp[2] = 8'h55;
        for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1);
        idle(20);
        n_vec++;
        if (got_n - g0 !== 3) begin
            n_err++;
            $display("FAIL b2b_count: got %0d, want 3", got_n - g0);
        end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (got_data[g0 + i] !== exp[i]) begin
                n_err++;
                $display("FAIL b2b_data%0d: got %h, want %h", i, got_data[g0 + i], exp[i]);
            end
        end
        n_vec++;
        if (fe_cnt - f0 !== 0 || ov_cnt - o0 !== 0) begin
            n_err++;
            $display("FAIL b2b_errors: got fe=%0d ov=%0d, want 0 0", fe_cnt - f0, ov_cnt - o0);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        rx_in = 1'b1;
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
